// File: rtl/program_encoder.sv
// program_encoder: serialises a latched block as length, address hi/lo, type, then data bytes
// over a valid/ready byte stream, counting every accepted byte.
module program_encoder #(
    parameter int DATA_BLOCK_MAX_SIZE = 64,
    parameter int COUNT_BITS          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    output logic                  error,
    input  logic [7:0]            block_length,
    input  logic [15:0]           block_address,
    input  logic [7:0]            block_type,
    input  logic [7:0]            block_data [DATA_BLOCK_MAX_SIZE],
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_BITS-1:0] byte_count
);
    localparam int IW = $clog2(DATA_BLOCK_MAX_SIZE + 1);
    localparam int AW = DATA_BLOCK_MAX_SIZE > 1 ? $clog2(DATA_BLOCK_MAX_SIZE) : 1;
    localparam logic [8:0] MAX_LEN = 9'(DATA_BLOCK_MAX_SIZE);

    typedef enum logic [2:0] {IDLE, LEN, ADDR_H, ADDR_L, TYPE, DATA} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              len_q, type_q;
    logic [15:0]             addr_q;
    logic [7:0]              data_q [DATA_BLOCK_MAX_SIZE];
    logic [IW-1:0]           idx_q, idx_d;
    logic                    done_q, done_d, error_q, error_d;
    logic [COUNT_BITS-1:0]   cnt_q;
    logic                    xfer, accept, last;

    assign ready      = state_q == IDLE;
    assign out_valid  = state_q != IDLE;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = cnt_q;
    assign xfer       = out_valid && out_ready;
    assign last       = 9'(idx_q) + 9'd1 == {1'b0, len_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                accept  = start && ({1'b0, block_length} <= MAX_LEN);
                error_d = start && ({1'b0, block_length} > MAX_LEN);
                state_d = accept ? LEN : IDLE;
            end
            LEN:    state_d = xfer ? ADDR_H : LEN;
            ADDR_H: state_d = xfer ? ADDR_L : ADDR_H;
            ADDR_L: state_d = xfer ? TYPE : ADDR_L;
            TYPE: if (xfer) begin
                idx_d   = '0;
                done_d  = len_q == 8'd0;
                state_d = done_d ? IDLE : DATA;
            end
            DATA: if (xfer) begin
                done_d  = last;
                idx_d   = last ? '0 : idx_q + IW'(1);
                state_d = last ? IDLE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data = 8'h00;
        case (state_q)
            LEN:     out_data = len_q;
            ADDR_H:  out_data = addr_q[15:8];
            ADDR_L:  out_data = addr_q[7:0];
            TYPE:    out_data = type_q;
            DATA:    out_data = data_q[idx_q[AW-1:0]];
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            error_q <= error_d;
            cnt_q   <= cnt_q + COUNT_BITS'(xfer);
            if (accept) begin
                len_q  <= block_length;
                addr_q <= block_address;
                type_q <= block_type;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data_q <= '{default: '0};
        else if (accept)
            data_q <= block_data;
    end
endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: random blocks, backpressure, illegal lengths, busy start and reset,
// scored against the stream format expected for each issued block.
module tb_program_encoder;
    localparam int MAX = 64;

    logic        clk = 1'b0;
    logic        rst, start, ready, done, error, out_valid, out_ready;
    logic [7:0]  block_length, block_type, out_data;
    logic [15:0] block_address, byte_count;
    logic [7:0]  block_data [MAX];
    logic [7:0]  dbuf [MAX];
    logic [7:0]  exp_q [$];
    logic [7:0]  prev_data;
    logic        prev_stall = 1'b0;
    int errors = 0, checks = 0, xfers = 0, dones = 0, errs_seen = 0;
    int exp_dones = 0, exp_total = 0, rmode = 0;

    program_encoder #(.DATA_BLOCK_MAX_SIZE(MAX), .COUNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done), .error(error),
        .block_length(block_length), .block_address(block_address), .block_type(block_type),
        .block_data(block_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // downstream: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) begin
                out_ready = ph == 0;
                ph = (ph + 1) % 3;
            end else out_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor: pop expected bytes on each transfer, check stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", out_data);
                end else chk("stream_byte", out_data, exp_q.pop_front());
            end
            if (rst && prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_data, prev_data);
            end
            if (rst && done) dones++;
            if (rst && error) errs_seen++;
            prev_stall = rst && out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_start", ready, 1);
    endtask

    task automatic scramble();
        block_length  = 8'($urandom);
        block_address = 16'($urandom);
        block_type    = 8'($urandom);
        for (int i = 0; i < MAX; i++) block_data[i] = 8'($urandom);
    endtask

    task automatic issue(input logic [7:0] len, input logic [15:0] addr, input logic [7:0] typ);
        wait_ready();
        block_length  = len;
        block_address = addr;
        block_type    = typ;
        block_data    = dbuf;
        exp_q.push_back(len);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(typ);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(dbuf[i]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic run_block(input logic [7:0] len, input logic [15:0] addr, input logic [7:0] typ,
                             input bit busy);
        int cyc = 0;
        bit got = 0;
        issue(len, addr, typ);
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
            else if (busy && cyc == 8) begin
                chk("busy_not_ready", ready, 0);
                start = 1'b1;
                block_length = 8'd3;
            end else if (busy && cyc == 9) start = 1'b0;
        end
        chk("done_seen", got, 1);
        chk("ready_at_done", ready, 1);
        if (rmode == 0) chk("block_cycles", cyc, int'(len) + 5);
        exp_total += 4 + int'(len);
        exp_dones++;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("byte_count", byte_count, exp_total & 16'hFFFF);
    endtask

    task automatic illegal(input logic [7:0] len);
        wait_ready();
        block_length = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("error_pulse", error, 1);
        chk("error_no_valid", out_valid, 0);
        chk("error_ready", ready, 1);
        @(negedge clk);
        chk("error_one_cycle", error, 0);
        chk("error_still_idle", out_valid, 0);
    endtask

    initial begin
        int base, n;
        rst = 1'b0;
        start = 1'b0;
        block_length = '0;
        block_address = '0;
        block_type = '0;
        block_data = '{default: '0};
        dbuf = '{default: '0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", byte_count, 0);
        @(negedge clk);
        rst = 1'b1;

        dbuf[0] = 8'hAA;
        dbuf[1] = 8'h55;
        run_block(8'd2, 16'h1234, 8'h00, 0);
        run_block(8'd0, 16'hFFFF, 8'h01, 0);
        rmode = 1;
        run_block(8'd2, 16'h1234, 8'h00, 0);
        rmode = 0;
        illegal(8'(MAX + 1));
        illegal(8'hFF);
        rmode = 2;
        for (int i = 0; i < MAX; i++) dbuf[i] = 8'($urandom);
        run_block(8'(MAX), 16'($urandom), 8'($urandom), 0);
        rmode = 0;
        run_block(8'd20, 16'hBEEF, 8'h7E, 1);
        for (int k = 0; k < 20; k++) begin
            rmode = $urandom_range(0, 2);
            for (int i = 0; i < MAX; i++) dbuf[i] = 8'($urandom);
            run_block(8'($urandom_range(0, MAX)), 16'($urandom), 8'($urandom), 0);
        end

        rmode = 0;
        base = xfers;
        issue(8'd10, 16'hCAFE, 8'h42);
        n = 0;
        while (xfers < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("three_transfers", xfers - base, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", byte_count, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_data", out_data, 0);
        exp_q.delete();
        exp_total = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < MAX; i++) dbuf[i] = 8'($urandom);
        run_block(8'd5, 16'h0102, 8'h03, 0);

        chk("total_dones", dones, exp_dones);
        chk("total_errors", errs_seen, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
